// File: rtl/rv_pkg.sv
// Shared register-writeback types and sizes: architectural widths, load-buffer
// depth, the writeback entry carried through the buffer, and a register mask helper.
package rv_pkg;

   localparam int REG_ADDR_W    = 5;
   localparam int XLEN          = 32;
   localparam int NUM_REGS      = 32;
   localparam int LD_FIFO_DEPTH = 2;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_entry_t;

   localparam int WB_ENTRY_W = $bits(wb_entry_t);

   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_LOAD,
      SRC_ALU
   } wb_src_e;

   // One-hot mask for a register; x0 is hardwired and never gets a bit.
   function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_ADDR_W-1:0] rd);
      reg_mask = '0;
      if (rd != '0) reg_mask[rd] = 1'b1;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO with valid/ready on both sides and a synchronous clear.
// Pointers wrap modulo DEPTH; occupancy is kept in a separate counter.
module wb_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             push;
   logic             pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) next_ptr = '0;
      else                        next_ptr = p + 1'b1;
   endfunction

   assign in_ready  = (count != CNT_W'(DEPTH));
   assign out_valid = (count != '0);
   assign out_data  = mem[rd_ptr];
   assign push      = in_valid && in_ready && !clear;
   assign pop       = out_valid && out_ready && !clear;

   // NOTE: storage is deliberately not reset; count gates every read, so stale
   // contents are never observed and the array stays plain RAM/flops without reset fan-out.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/reg_writeback.sv
// Register-file writeback arbiter: buffered load results win over ALU results, and a
// busy scoreboard tracks outstanding loads. Define REG_WRITEBACK_FORWARD_EN for bypass ports.
module reg_writeback
   import rv_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  issue_valid,
   input  logic [REG_ADDR_W-1:0] issue_rd,
   input  logic                  alu_valid,
   input  logic [REG_ADDR_W-1:0] alu_rd,
   input  logic [XLEN-1:0]       alu_data,
   output logic                  alu_ready,
   input  logic                  ld_valid,
   input  logic [REG_ADDR_W-1:0] ld_rd,
   input  logic [XLEN-1:0]       ld_data,
   output logic                  ld_ready,
   input  logic                  flush,
   input  logic [REG_ADDR_W-1:0] rs1,
   input  logic [REG_ADDR_W-1:0] rs2,
   output logic                  rs1_busy,
   output logic                  rs2_busy,
`ifdef REG_WRITEBACK_FORWARD_EN
   output logic                  fwd1_hit,
   output logic                  fwd2_hit,
   output logic [XLEN-1:0]       fwd1_data,
   output logic [XLEN-1:0]       fwd2_data,
`endif
   output logic                  reg_write,
   output logic [REG_ADDR_W-1:0] write_register,
   output logic [XLEN-1:0]       write_data
);

   wb_entry_t           ld_entry;
   wb_entry_t           head_entry;
   wb_entry_t           sel_entry;
   logic [WB_ENTRY_W-1:0] head_bits;
   logic                fifo_in_ready;
   logic                fifo_empty_n;
   wb_src_e             sel_src;
   logic                wb_is_load;
   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] set_mask;
   logic [NUM_REGS-1:0] clr_mask;

   assign ld_entry   = '{rd: ld_rd, data: ld_data};
   assign head_entry = wb_entry_t'(head_bits);

   wb_fifo #(
      .DEPTH (LD_FIFO_DEPTH),
      .WIDTH (WB_ENTRY_W)
   ) u_ld_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (flush),
      .in_valid  (ld_valid && !flush),
      .in_ready  (fifo_in_ready),
      .in_data   (ld_entry),
      .out_valid (fifo_empty_n),
      .out_ready (!flush),
      .out_data  (head_bits)
   );

   assign ld_ready  = fifo_in_ready && !flush;
   assign alu_ready = !fifo_empty_n && !flush;

   // Source selection; the FIFO head is popped whenever it is present and not flushing.
   always_comb begin
      sel_src   = SRC_NONE;
      sel_entry = '0;
      if (fifo_empty_n) begin
         sel_src   = SRC_LOAD;
         sel_entry = head_entry;
      end else if (alu_valid && alu_ready) begin
         sel_src   = SRC_ALU;
         sel_entry = '{rd: alu_rd, data: alu_data};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_write      <= 1'b0;
         write_register <= '0;
         write_data     <= '0;
         wb_is_load     <= 1'b0;
      end else if (flush) begin
         reg_write  <= 1'b0;
         wb_is_load <= 1'b0;
      end else begin
         case (sel_src)
            SRC_LOAD, SRC_ALU: begin
               reg_write      <= (sel_entry.rd != '0);
               write_register <= sel_entry.rd;
               write_data     <= sel_entry.data;
               wb_is_load     <= (sel_src == SRC_LOAD);
            end
            default: begin
               reg_write  <= 1'b0;
               wb_is_load <= 1'b0;
            end
         endcase
      end
   end

   // A load's busy bit drops at the end of the cycle its write is presented, so a
   // reader without forwarding sees the register file already updated afterwards.
   assign clr_mask = (reg_write && wb_is_load) ? reg_mask(write_register) : '0;
   assign set_mask = issue_valid ? reg_mask(issue_rd) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     busy <= '0;
      else if (flush) busy <= '0;
      else            busy <= (busy & ~clr_mask) | set_mask;
   end

   assign rs1_busy = busy[rs1];
   assign rs2_busy = busy[rs2];

`ifdef REG_WRITEBACK_FORWARD_EN
   assign fwd1_hit  = reg_write && (write_register == rs1) && (rs1 != '0);
   assign fwd2_hit  = reg_write && (write_register == rs2) && (rs2 != '0);
   assign fwd1_data = write_data;
   assign fwd2_data = write_data;
`endif

endmodule
